// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC register, instruction memory addressing and IF/ID register.
// Define IFETCH_PERF_CNT_EN to add the FetchCount/BubbleCount performance counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Fault,
    output logic [31:0] FaultAddr
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, stateNext;
    logic [31:0] pc, pcNext, pcPlus4;
    logic [31:0] instrNext, pcPlus4Next, faultAddrNext;
    logic        validNext, faultNext;
    logic        redirect;
    logic [31:0] target;

    assign IMemAddr = pc;
    assign pcPlus4  = pc + 32'd4;
    assign redirect = Jump | BranchTaken;
    // Jump outranks a simultaneous branch.
    assign target   = Jump ? JumpTarget : BranchTarget;

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        instrNext     = IF_ID_Instr;
        pcPlus4Next   = IF_ID_PCPlus4;
        validNext     = IF_ID_Valid;
        faultNext     = Fault;
        faultAddrNext = FaultAddr;
        case (state)
            RUN: begin
                if (redirect) begin
                    instrNext   = NOP_WORD;
                    pcPlus4Next = 32'h0;
                    validNext   = 1'b0;
                    if (target[1:0] != 2'b00) begin
                        stateNext     = HALT;
                        faultNext     = 1'b1;
                        faultAddrNext = target;
                    end else begin
                        pcNext = target;
                    end
                end else begin
                    if (Flush) begin
                        instrNext   = NOP_WORD;
                        pcPlus4Next = 32'h0;
                        validNext   = 1'b0;
                    end else if (!Stall) begin
                        instrNext   = IMemData;
                        pcPlus4Next = pcPlus4;
                        validNext   = 1'b1;
                    end
                    if (!Stall) begin
                        pcNext = pcPlus4;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            IF_ID_Instr   <= NOP_WORD;
            IF_ID_PCPlus4 <= 32'h0;
            IF_ID_Valid   <= 1'b0;
            Fault         <= 1'b0;
            FaultAddr     <= 32'h0;
        end else begin
            state         <= stateNext;
            pc            <= pcNext;
            IF_ID_Instr   <= instrNext;
            IF_ID_PCPlus4 <= pcPlus4Next;
            IF_ID_Valid   <= validNext;
            Fault         <= faultNext;
            FaultAddr     <= faultAddrNext;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic loadValid, loadBubble;

    assign loadBubble = (state == RUN) && (redirect || Flush);
    assign loadValid  = (state == RUN) && !redirect && !Flush && !Stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            FetchCount  <= 32'h0;
            BubbleCount <= 32'h0;
        end else begin
            if (loadValid) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (loadBubble) begin
                BubbleCount <= BubbleCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: spec-level model compared every cycle,
// plus directed literal checks. Memory returns word[i] = i + 1.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        Stall, Flush, BranchTaken, Jump;
    logic [31:0] BranchTarget, JumpTarget;
    logic [31:0] IMemAddr, IMemData;
    logic [31:0] IF_ID_Instr, IF_ID_PCPlus4, FaultAddr;
    logic        IF_ID_Valid, Fault;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] FetchCount, BubbleCount;
`endif

    int assertions = 0;
    int failures   = 0;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .IMemAddr(IMemAddr), .IMemData(IMemData),
        .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid(IF_ID_Valid), .Fault(Fault), .FaultAddr(FaultAddr)
`ifdef IFETCH_PERF_CNT_EN
        , .FetchCount(FetchCount), .BubbleCount(BubbleCount)
`endif
    );

    assign IMemData = (IMemAddr >> 2) + 32'd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Spec-level model state
    logic [31:0] mPc, mInstr, mPcPlus4, mFaultAddr, mFetch, mBubble, mTarget;
    logic        mValid, mFault, mHalted, modelReady;

    initial modelReady = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mPc = 32'h0; mInstr = 32'h0; mPcPlus4 = 32'h0; mValid = 1'b0;
            mFault = 1'b0; mFaultAddr = 32'h0; mHalted = 1'b0;
            mFetch = 32'h0; mBubble = 32'h0;
            modelReady = 1'b1;
        end else if (modelReady && !mHalted) begin
            if (Jump || BranchTaken) begin
                mTarget = Jump ? JumpTarget : BranchTarget;
                mInstr = 32'h0; mPcPlus4 = 32'h0; mValid = 1'b0;
                mBubble = mBubble + 1;
                if (mTarget % 4 != 0) begin
                    mHalted = 1'b1; mFault = 1'b1; mFaultAddr = mTarget;
                end else begin
                    mPc = mTarget;
                end
            end else begin
                if (Flush) begin
                    mInstr = 32'h0; mPcPlus4 = 32'h0; mValid = 1'b0;
                    mBubble = mBubble + 1;
                end else if (!Stall) begin
                    mInstr = mPc / 4 + 1; mPcPlus4 = mPc + 4; mValid = 1'b1;
                    mFetch = mFetch + 1;
                end
                if (!Stall) mPc = mPc + 4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("model IMemAddr", IMemAddr, mPc);
            checkOutput("model IF_ID_Instr", IF_ID_Instr, mInstr);
            checkOutput("model IF_ID_PCPlus4", IF_ID_PCPlus4, mPcPlus4);
            checkOutput("model IF_ID_Valid", {31'h0, IF_ID_Valid}, {31'h0, mValid});
            checkOutput("model Fault", {31'h0, Fault}, {31'h0, mFault});
            checkOutput("model FaultAddr", FaultAddr, mFaultAddr);
`ifdef IFETCH_PERF_CNT_EN
            checkOutput("model FetchCount", FetchCount, mFetch);
            checkOutput("model BubbleCount", BubbleCount, mBubble);
`endif
        end
    end

    // Drives inputs now (at a falling edge), lets one rising edge pass, returns at the next falling edge.
    task automatic applyStimulus(input logic r, input logic st, input logic fl,
                                 input logic br, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt);
        rst = r; Stall = st; Flush = fl;
        BranchTaken = br; BranchTarget = bt; Jump = j; JumpTarget = jt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic checkIfId(input string name, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] p4, input logic v);
        checkOutput({name, " PC"}, IMemAddr, pc);
        checkOutput({name, " Instr"}, IF_ID_Instr, instr);
        checkOutput({name, " PCPlus4"}, IF_ID_PCPlus4, p4);
        checkOutput({name, " Valid"}, {31'h0, IF_ID_Valid}, {31'h0, v});
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkIfId("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset Fault", {31'h0, Fault}, 32'h0);

        idle(3);
        checkIfId("three fetches", 32'd12, 32'd3, 32'd12, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkIfId("stall hold", 32'd8, 32'd2, 32'd8, 1'b1);
        idle(1);
        checkIfId("stall release", 32'd12, 32'd3, 32'd12, 1'b1);

        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        checkIfId("branch bubble", 32'h40, 32'h0, 32'h0, 1'b0);
        idle(1);
        checkIfId("branch target", 32'h44, 32'h11, 32'h44, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        checkIfId("jump wins", 32'h80, 32'h0, 32'h0, 1'b0);
        idle(1);
        checkIfId("jump target", 32'h84, 32'h21, 32'h84, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkIfId("flush", 32'h88, 32'h0, 32'h0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkIfId("flush over stall", 32'h8C, 32'h0, 32'h0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        idle(1);
        checkIfId("pc wrap", 32'h0, 32'h4000_0000, 32'h0, 1'b1);
        idle(1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
        checkOutput("fault flag", {31'h0, Fault}, 32'h1);
        checkOutput("fault addr", FaultAddr, 32'h102);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        idle(2);
        checkIfId("halted", 32'h4, 32'h0, 32'h0, 1'b0);
        checkOutput("halted fault", {31'h0, Fault}, 32'h1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        checkIfId("reset from halt", 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset clears fault", {31'h0, Fault}, 32'h0);
        idle(2);
        checkIfId("restart", 32'h8, 32'h2, 32'h8, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS pipeline: owns the program counter, drives the address of the combinational `InstructionMemory`, and captures the returned word into the IF/ID pipeline register. It sits directly upstream of `InstructionMemory` and the decode stage, and accepts stall, flush and branch/jump redirects from ID. A misaligned redirect target halts fetch until reset and raises a fault flag.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_WORD`, 32'h0000_0000, instruction word placed in IF/ID on a bubble.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Stall`  in  1  hold PC and IF/ID contents.
- `Flush`  in  1  load a bubble into IF/ID next edge.
- `BranchTaken`  in  1  redirect to `BranchTarget`.
- `BranchTarget`  in  32  branch destination.
- `Jump`  in  1  redirect to `JumpTarget`.
- `JumpTarget`  in  32  jump destination.
- `IMemAddr`  out  32  address to `InstructionMemory` (= PC).
- `IMemData`  in  32  instruction word from `InstructionMemory`.
- `IF_ID_Instr`  out  32  registered instruction.
- `IF_ID_PCPlus4`  out  32  registered PC+4 of that instruction.
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction.
- `Fault`  out  1  misaligned redirect seen; fetch halted.
- `FaultAddr`  out  32  offending target address.

## Operation
- State machine: RUN, HALT. Reset -> RUN.
- RUN, each edge, priority order:
  1. `Jump` (target aligned): PC <= `JumpTarget`; IF/ID <= bubble.
  2. `BranchTaken` (target aligned): PC <= `BranchTarget`; IF/ID <= bubble.
  3. Selected redirect target with bits [1:0] != 0: -> HALT; `Fault`<=1; `FaultAddr`<=target; IF/ID <= bubble; PC holds.
  4. `Stall`: PC and IF/ID hold.
  5. Otherwise: PC <= PC+4; IF/ID <= {`IMemData`, PC+4, valid=1}.
- `Jump` and `BranchTaken` together: jump wins; branch ignored.
- Redirect overrides `Stall` (redirect implies ID has resolved).
- `Flush` (no redirect): IF/ID <= bubble; PC advances by +4 unless `Stall`, in which case PC holds. `Flush` beats `Stall` for IF/ID.
- Bubble = {`NOP_WORD`, 32'h0, valid=0}.
- HALT: PC, IF/ID held as bubble, all inputs ignored; only `rst` exits.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0), no flag.

## Timing
- Reset values: PC=`RESET_PC`, `IMemAddr`=`RESET_PC`, `IF_ID_Instr`=`NOP_WORD`, `IF_ID_PCPlus4`=0, `IF_ID_Valid`=0, `Fault`=0, `FaultAddr`=0, state RUN.
- `IMemAddr` is combinational from PC register; `IMemData` sampled same cycle (memory is combinational).
- Latency: word at PC appears on `IF_ID_Instr` one edge after PC is presented. First valid instruction on first edge after `rst` deasserts.
- Redirect penalty: one bubble cycle; target instruction valid two edges after redirect asserted.
- `rst` asserted mid-operation (including HALT, or during stall/redirect): reset values on that edge, no partial update.

## Configuration
- `IFETCH_PERF_CNT_EN` defined: adds outputs `FetchCount` [31:0] (increments on each edge loading a valid instruction into IF/ID) and `BubbleCount` [31:0] (increments on each edge loading a bubble while in RUN, not during reset); both reset to 0, wrap silently.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset with `RESET_PC`=0, memory word[i]=i+1 -> after 3 edges `IF_ID_Instr`=3, `IF_ID_PCPlus4`=12, `IMemAddr`=12, `IF_ID_Valid`=1.
- `Stall` high 2 cycles at PC=8 -> PC stays 8, IF/ID unchanged, resumes with PC=12 after release.
- `BranchTaken`=1, `BranchTarget`=0x40 at PC=0x10 -> next edge PC=0x40, `IF_ID_Valid`=0; following edge `IF_ID_PCPlus4`=0x44, valid=1.
- `Jump`=1 to 0x80 with `BranchTaken`=1 to 0x40 and `Stall`=1 -> PC=0x80, bubble in IF/ID.
- `JumpTarget`=0x102 -> `Fault`=1, `FaultAddr`=0x102, valid stays 0 under further stimulus; `rst` restores PC=`RESET_PC`, `Fault`=0.
- PC=32'hFFFF_FFFC, no stall -> PC wraps to 0, `IF_ID_PCPlus4`=0; with `IFETCH_PERF_CNT_EN`, `FetchCount` and `BubbleCount` match the valid/bubble edges counted across all the above.
